// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the RV32I writeback stage: load funct3 encodings,
// FSM states and the zero register index.
package writeback_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load alignment and sign/zero extension with fault detection
// (misaligned halfword/word or illegal funct3).
module load_extend
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] value,
    output logic        fault
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        value = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB:  value = 32'(byte_sel);
            F3_LH: begin
                value = 32'(half_sel);
                fault = addr_lo[0];
            end
            F3_LW: begin
                value = rdata;
                fault = (addr_lo != 2'd0);
            end
            F3_LBU: value = {24'd0, byte_sel};
            F3_LHU: begin
                value = {16'd0, half_sel};
                fault = addr_lo[0];
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage: retires ALU results, waits for load data,
// drives a one-cycle register-file write strobe and counts retirements.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd_addr,
    output logic [31:0] w_val,
    output logic        pend_valid,
    output logic [4:0]  pend_rd,
    output logic        err,
    output logic [31:0] instret
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    wb_state_e   state, state_next;
    logic [4:0]  rd_lat;
    logic [2:0]  f3_lat;
    logic [1:0]  addr_lat;
    logic [7:0]  tcnt, tcnt_next;
    logic [4:0]  rd_addr_next;
    logic [31:0] w_val_next;
    logic        retire, err_set, latch;
    logic [31:0] ext_value;
    logic        ext_fault;

    load_extend u_load_extend (
        .funct3  (f3_lat),
        .addr_lo (addr_lat),
        .rdata   (dmem_rdata),
        .value   (ext_value),
        .fault   (ext_fault)
    );

    assign ex_ready   = (state == IDLE);
    assign pend_valid = (state == WAIT_MEM);
    assign pend_rd    = pend_valid ? rd_lat : REG_ZERO;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        tcnt_next    = tcnt;
        rd_addr_next = REG_ZERO;
        w_val_next   = '0;
        retire       = 1'b0;
        err_set      = 1'b0;
        latch        = 1'b0;
        case (state)
            IDLE: begin
                // A stray response is flagged but does not block acceptance.
                err_set = dmem_rvalid;
                if (ex_valid) begin
                    if (ex_is_load) begin
                        latch      = 1'b1;
                        tcnt_next  = '0;
                        state_next = WAIT_MEM;
                    end else begin
                        rd_addr_next = ex_rd;
                        w_val_next   = ex_result;
                        retire       = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Data takes priority over a timeout landing in the same cycle.
                if (dmem_rvalid) begin
                    state_next = IDLE;
                    if (ext_fault) begin
                        err_set = 1'b1;
                    end else begin
                        rd_addr_next = rd_lat;
                        w_val_next   = ext_value;
                        retire       = 1'b1;
                    end
                end else if (tcnt == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else begin
                    tcnt_next = tcnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr <= REG_ZERO;
            w_val   <= '0;
            err     <= 1'b0;
            instret <= '0;
            tcnt    <= '0;
        end else begin
            rd_addr <= rd_addr_next;
            w_val   <= w_val_next;
            err     <= err | err_set;
            instret <= instret + {31'd0, retire};
            tcnt    <= tcnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (latch) begin
            rd_lat   <= ex_rd;
            f3_lat   <= ex_funct3;
            addr_lat <= ex_addr_lo;
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core; sits directly upstream of the register file.
- Accepts completed ALU results and load requests from execute, then waits for the data-memory response.
- Aligns and sign/zero-extends load data, then drives the register file's write port (rd_addr/w_val) for exactly one cycle per retired instruction.
- The register file writes on every clock, so this block holds rd_addr at 0 whenever no write is intended. It also maintains the retired-instruction counter and a pending-load indication for decode-stage stalling.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait in WAIT_MEM for dmem_rvalid before abandoning the load (range 1..255).

Ports:
- clock  in  1  single core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_ready  out  1  writeback can accept (combinational from state: 1 in IDLE only).
- ex_rd  in  5  destination register.
- ex_result  in  32  ALU/JAL/LUI result (ignored for loads).
- ex_is_load  in  1  instruction is a load.
- ex_funct3  in  3  load width: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- ex_addr_lo  in  2  load effective address bits [1:0].
- dmem_rvalid  in  1  memory read data valid (single-cycle pulse).
- dmem_rdata  in  32  aligned 32-bit word containing the load target.
- rd_addr  out  5  register file write address; 0 means no write.
- w_val  out  32  register file write data.
- pend_valid  out  1  a load is outstanding.
- pend_rd  out  5  rd of the outstanding load (0 when pend_valid=0).
- err  out  1  sticky error flag.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset values (synchronous, takes effect at the next posedge while reset=1): state=IDLE, rd_addr=0, w_val=0, pend_valid=0, pend_rd=0, err=0, instret=0, timeout counter=0.
- Reset mid-load drops the pending load; no write is issued for it.
- Write strobe: rd_addr/w_val are registered. They default to rd_addr=0 and w_val=0 every cycle unless a write is issued; a write is visible for exactly one cycle.
- IDLE, ex_valid=1, ex_is_load=0:
  - Next cycle: rd_addr=ex_rd, w_val=ex_result, instret+=1.
  - Latency is 1 cycle; back-to-back acceptance every cycle.
  - ex_rd=0 still retires (instret increments) with rd_addr=0.
- IDLE, ex_valid=1, ex_is_load=1:
  - Latch rd, funct3 and addr_lo; clear the timeout counter; go to WAIT_MEM.
  - pend_valid=1 and pend_rd=rd from the next cycle.
- WAIT_MEM:
  - ex_ready=0; the timeout counter increments each cycle.
  - On dmem_rvalid: next cycle rd_addr=latched rd, w_val=extended data, instret+=1, pend_valid=0, state=IDLE. ex_ready returns to 1 in that same cycle.
- Timeout: when the counter reaches MEM_TIMEOUT-1 without dmem_rvalid, set err, issue no write, do not increment instret, return to IDLE and clear pend_valid.
- If dmem_rvalid coincides with the final timeout cycle, the data wins: the load completes normally and err is unchanged.
- Extraction: byte = dmem_rdata[8*addr_lo +: 8]; half = dmem_rdata[16*addr_lo[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Load fault: misalignment (LH/LHU with addr_lo[0]=1, LW with addr_lo≠0) or illegal funct3 (3, 6, 7).
  - Checked when dmem_rvalid arrives.
  - Sets err, issues no write, does not increment instret, returns to IDLE.
- Stray dmem_rvalid in IDLE: ignored; sets err.
- A simultaneous ex_valid in that same cycle is still accepted normally.
- instret wraps from 0xFFFFFFFF to 0.
- err clears only on reset.

Decomposition:
- Shared core package holds:
  - load funct3 encodings: LB=0, LH=1, LW=2, LBU=4, LHU=5;
  - the state enum {IDLE, WAIT_MEM};
  - constant REG_ZERO=5'd0.
- One natural sub-module: load_extend, a combinational funct3/addr_lo/rdata → 32-bit value plus fault flag, reusable by a future store-forwarding path.

Test Plan:
- Non-load stream: ex_rd=5, result 0x12345678, then ex_rd=6, result 0xCAFEBABE on consecutive cycles.
  - Required: rd_addr 5 then 6 on the following two cycles with matching w_val, then 0; instret=2.
- Load paths, each with dmem_rvalid 3 cycles after acceptance:
  - LB, addr_lo=3, dmem_rdata=0x80FF7F01 → rd_addr=10, w_val=0xFFFFFF80.
  - LBU, same data → w_val=0x00000080.
  - LHU, addr_lo=2 → w_val=0x000080FF.
  - During the wait: ex_ready=0, pend_valid=1, pend_rd=10.
- Misaligned LW, addr_lo=1 → rd_addr stays 0, err=1, instret unchanged, ex_ready=1 the cycle after rvalid.
- Timeout: load accepted, no dmem_rvalid for MEM_TIMEOUT=16 cycles.
  - Required: err=1, no write, pend_valid=0, back in IDLE.
  - A dmem_rvalid arriving on exactly cycle 16 instead completes the load with err=0.
- Reset asserted while in WAIT_MEM, then dmem_rvalid one cycle after reset deasserts.
  - Required: all outputs 0 and no write; err=1 from the stray rvalid.
- instret preloaded via 2^32-1 retirements (or forced) plus one more retirement → instret=0.
